// File: rtl/inc_pulse_gen.sv
// Button-to-increment pulse generator: synchronizes and debounces a bouncy press
// input, emits one registered inc pulse per accepted press, plus optional auto-repeat.
module inc_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic async_reset,
  input  logic btn_raw,
  input  logic enable,
  input  logic repeat_en,
  output logic inc,
  output logic held
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] DELAY_LD  = 8'(REPEAT_DELAY);
  localparam logic [7:0] PERIOD_LD = 8'(REPEAT_PERIOD);
  localparam bit         DB_ONE    = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [1:0]             state_q, state_d;
  logic [7:0]             db_cnt_q, db_cnt_d;
  logic [7:0]             rpt_q, rpt_d;
  logic                   req_q, req_d;
  logic                   inc_q, held_q;

  assign btn_s = sync_q[SYNC_STAGES-1];
  assign inc   = inc_q;
  assign held  = held_q;

  // Next-state logic; req_d marks the cycle a pulse is generated, inc follows one cycle later.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    rpt_d    = rpt_q;
    req_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          if (DB_ONE) begin
            state_d  = ST_HELD;
            db_cnt_d = 8'd0;
            rpt_d    = DELAY_LD;
            req_d    = 1'b1;
          end else begin
            state_d  = ST_PRESS_DB;
            db_cnt_d = 8'd1;
          end
        end else begin
          db_cnt_d = 8'd0;
        end
      end
      ST_PRESS_DB: begin
        if (!btn_s) begin
          state_d  = ST_IDLE;
          db_cnt_d = 8'd0;
        end else if (db_cnt_q >= DB_LAST) begin
          state_d  = ST_HELD;
          db_cnt_d = 8'd0;
          rpt_d    = DELAY_LD;
          req_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 8'd1;
        end
      end
      ST_HELD: begin
        // Expiry waits one cycle if a pulse is still pending, keeping inc pulses non-adjacent.
        if (repeat_en) begin
          if (rpt_q <= 8'd1 && !req_q) begin
            rpt_d = PERIOD_LD;
            req_d = 1'b1;
          end else if (rpt_q > 8'd1) begin
            rpt_d = rpt_q - 8'd1;
          end else begin
            rpt_d = rpt_q;
          end
        end else begin
          rpt_d = rpt_q;
        end
        if (!btn_s) begin
          if (DB_ONE) begin
            state_d  = ST_IDLE;
            db_cnt_d = 8'd0;
          end else begin
            state_d  = ST_RELEASE_DB;
            db_cnt_d = 8'd1;
          end
        end else begin
          db_cnt_d = 8'd0;
        end
      end
      ST_RELEASE_DB: begin
        if (btn_s) begin
          state_d  = ST_HELD;
          db_cnt_d = 8'd0;
        end else if (db_cnt_q >= DB_LAST) begin
          state_d  = ST_IDLE;
          db_cnt_d = 8'd0;
        end else begin
          db_cnt_d = db_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        db_cnt_d = 8'd0;
        rpt_d    = 8'd0;
      end
    endcase
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      sync_q   <= '0;
      state_q  <= ST_IDLE;
      db_cnt_q <= 8'd0;
      rpt_q    <= 8'd0;
      req_q    <= 1'b0;
      inc_q    <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      rpt_q    <= rpt_d;
      req_q    <= req_d;
      inc_q    <= req_q & enable;
      held_q   <= (state_q == ST_HELD) || (state_q == ST_RELEASE_DB);
    end
  end

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Directed table-driven bench for inc_pulse_gen with default parameters.
module tb_inc_pulse_gen;

  logic clk = 1'b0;
  logic async_reset;
  logic btn_raw;
  logic enable;
  logic repeat_en;
  logic inc;
  logic held;

  inc_pulse_gen dut (
    .clk        (clk),
    .async_reset(async_reset),
    .btn_raw    (btn_raw),
    .enable     (enable),
    .repeat_en  (repeat_en),
    .inc        (inc),
    .held       (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic raw;
    logic en;
    logic rep;
    logic exp_inc;
    logic exp_held;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Entry k inputs are sampled on edge k; its expected outputs are those after edge k.
  task automatic add(input logic raw, input logic en, input logic rep,
                     input logic e_inc, input logic e_held, input int n);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.raw = raw; v.en = en; v.rep = rep; v.exp_inc = e_inc; v.exp_held = e_held;
      vecs.push_back(v);
    end
  endtask

  task automatic run(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      btn_raw   = vecs[i].raw;
      enable    = vecs[i].en;
      repeat_en = vecs[i].rep;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].inc", name, i), inc, vecs[i].exp_inc);
      check($sformatf("%s[%0d].held", name, i), held, vecs[i].exp_held);
    end
    vecs.delete();
  endtask

  task automatic do_reset(input string name);
    btn_raw     = 1'b0;
    async_reset = 1'b0;
    #2;
    check({name, ".rst_inc"}, inc, 1'b0);
    check({name, ".rst_held"}, held, 1'b0);
    async_reset = 1'b1;
  endtask

  initial begin
    async_reset = 1'b0;
    btn_raw     = 1'b0;
    enable      = 1'b1;
    repeat_en   = 1'b0;
    @(posedge clk);
    #1;
    check("reset.inc", inc, 1'b0);
    check("reset.held", held, 1'b0);
    async_reset = 1'b1;

    // Clean press, no repeat: single pulse 6 edges after first sampled high.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 13);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    run("clean");

    // Bounce 1,0,1,0 then stable high from entry 4: pulse at entry 10.
    do_reset("bounce");
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    run("bounce");

    // Auto-repeat: pulses at 6, 14, 18, 22, 26, 30; none once released.
    do_reset("repeat");
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7);
    for (int k = 0; k < 3; k++) begin
      add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
      add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3);
    end
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    run("repeat");

    // Release glitch: 2-cycle low while held; timer frozen 2 cycles, period kept.
    do_reset("glitch");
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    run("glitch");

    // Enable gating: enable low on the t0+8 cycle drops that pulse, t0+12 still fires.
    do_reset("gate");
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    run("gate");

    // Reset mid-hold right after a pulse: outputs clear without a clock edge.
    do_reset("midrst");
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    run("midrst_pre");
    async_reset = 1'b0;
    #1;
    check("midrst.async_inc", inc, 1'b0);
    check("midrst.async_held", held, 1'b0);
    #1;
    async_reset = 1'b1;
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    run("midrst_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inc_pulse_gen.md
INC_PULSE_GEN -- requirements
Module: inc_pulse_gen

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2: number of synchronizer flops on btn_raw, legal range 2..4.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a press or a release, legal range 1..255.
REQ-003 SHALL provide parameter REPEAT_DELAY, default 8: cycles from the first inc pulse to the first auto-repeat pulse, legal range 1..255.
REQ-004 SHALL provide parameter REPEAT_PERIOD, default 4: cycles between successive auto-repeat pulses, legal range 1..255.
REQ-005 SHALL provide port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 SHALL provide port async_reset, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL provide port btn_raw, input, 1 bit: asynchronous, bouncy, active-high press input.
REQ-008 SHALL provide port enable, input, 1 bit: synchronous; 0 blocks the inc output.
REQ-009 SHALL provide port repeat_en, input, 1 bit: synchronous; 1 allows auto-repeat while the button is held.
REQ-010 SHALL provide port inc, output, 1 bit: registered single-cycle increment pulse, driven straight into the downstream counter's inc input.
REQ-011 SHALL provide port held, output, 1 bit: registered level, 1 while a debounced press is active.

Function
REQ-012 SHALL pass btn_raw through a SYNC_STAGES-deep flop chain; btn_s is the last stage, and no other logic SHALL sample btn_raw.
REQ-013 SHALL implement FSM states IDLE, PRESS_DB, HELD, RELEASE_DB.
REQ-014 IDLE: btn_s=1 SHALL go to PRESS_DB with the debounce counter loaded to 1.
REQ-015 PRESS_DB: btn_s=1 SHALL increment the debounce counter; btn_s=0 SHALL return to IDLE and clear the counter.
REQ-016 PRESS_DB: on the DEBOUNCE_CYCLES-th consecutive btn_s=1 sample, SHALL go to HELD and pulse inc in the next cycle.
REQ-017 With btn_raw held high and setup met, inc SHALL rise exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples btn_raw=1 (default: 6).
REQ-018 HELD: btn_s=0 SHALL go to RELEASE_DB with the counter loaded to 1.
REQ-019 RELEASE_DB: btn_s=1 SHALL return to HELD without emitting a pulse and without restarting the repeat timer.
REQ-020 RELEASE_DB: the DEBOUNCE_CYCLES-th consecutive btn_s=0 sample SHALL go to IDLE.
REQ-021 held SHALL be 1 exactly while the state is HELD or RELEASE_DB.
REQ-022 The repeat timer SHALL be an 8-bit down-counter loaded with REPEAT_DELAY on press acceptance.
REQ-023 The repeat timer SHALL count down only while in HELD with repeat_en=1.
REQ-024 At repeat timer expiry, inc SHALL pulse and the timer SHALL reload with REPEAT_PERIOD; the timer SHALL never wrap below 0.
REQ-025 repeat_en=0 SHALL freeze the timer at its current value; re-asserting repeat_en SHALL resume from the frozen value.
REQ-026 inc SHALL never be high for two consecutive cycles: when REPEAT_PERIOD=1, pulses SHALL be spaced every 2 cycles.
REQ-027 inc SHALL be 0 whenever enable=0 in the cycle in which the pulse would be generated; suppressed pulses SHALL be dropped, not queued.
REQ-028 The FSM and timers SHALL advance independently of enable.
REQ-029 Acceptance and repeat expiry can never coincide; at most one pulse SHALL be generated per cycle.

Reset
REQ-030 async_reset=0 SHALL immediately clear the synchronizer, counters and outputs and force state IDLE: inc=0, held=0.
REQ-031 Assertion of async_reset SHALL take effect without a clock edge.
REQ-032 Deassertion of async_reset SHALL be followed by normal operation from the next rising edge.
REQ-033 A reset during PRESS_DB, HELD or RELEASE_DB SHALL emit no pulse on exit from reset.
REQ-034 A reset with btn_raw still high SHALL require a full new debounce before inc pulses.

Verification
REQ-035 Clean press (defaults): btn_raw 0->1 held for 20 cycles with repeat_en=0 -> exactly one inc pulse, 6 cycles after the first sampled high; held=1 from the same cycle.
REQ-036 Bounce: btn_raw toggles 1,0,1,0 every cycle, then stays 1 -> no pulse during the bounce; exactly one pulse after 4 stable samples.
REQ-037 Auto-repeat: hold for 30 cycles with repeat_en=1 -> pulses at t0, t0+8, t0+12, t0+16, t0+20, ...; no pulses after release debounce completes.
REQ-038 Release glitch: while HELD, a 2-cycle low on btn_raw -> held stays 1, no extra pulse, repeat cadence unchanged.
REQ-039 Enable gating: enable=0 on the cycle of the t0+8 pulse -> that pulse is missing and the t0+12 pulse still occurs.
REQ-040 Reset mid-hold: async_reset=0 between clock edges while HELD -> inc=0 and held=0 immediately; after release of async_reset with btn_raw=1 -> first pulse 6 cycles later.
